// File: rtl/renkon_linebuf_stride.sv
// renkon_linebuf_stride: sliding-window line buffer with runtime filter size,
// zero padding and stride. Raster pixels in, one packed F x F window out.
module renkon_linebuf_stride #(
    parameter int MAXFIL    = 5,
    parameter int MAXIMG    = 32,
    parameter int MAXSTRIDE = 4,
    parameter int DWIDTH    = 16,
    parameter int LWIDTH    = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            buf_req,
    input  logic [LWIDTH-1:0]               img_size,
    input  logic [LWIDTH-1:0]               fil_size,
    input  logic [LWIDTH-1:0]               pad_size,
    input  logic [LWIDTH-1:0]               stride_size,
    input  logic signed [DWIDTH-1:0]        buf_input,
    output logic                            buf_ack,
    output logic                            buf_ready,
    output logic                            buf_valid,
    output logic [MAXFIL*MAXFIL*DWIDTH-1:0] buf_output
);
    // Internal arithmetic carries two guard bits so N+2P never overflows.
    localparam int XW = LWIDTH + 2;
    localparam int AW = (MAXIMG > 1) ? $clog2(MAXIMG) : 1;
    localparam int SW = (MAXFIL > 1) ? $clog2(MAXFIL) : 1;
    localparam int WB = MAXFIL * MAXFIL * DWIDTH;

    typedef enum logic [2:0] {S_WAIT, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_n;

    // Latched job configuration
    logic [XW-1:0] n_r, f_r, p_r, s_r;
    // Issue side (what upstream is asked for), commit side (what is in memory)
    logic [XW-1:0] in_row, in_col, in_sel;
    logic [XW-1:0] cm_row, cm_col;
    // Current window: padded top-left corner and line holding its top row
    logic [XW-1:0] row_base, col_base, top_sel;
    logic          win_done;

    logic          wr_vld_p0;
    logic [SW-1:0] wr_sel_p0;
    logic [AW-1:0] wr_col_p0;

    logic signed [DWIDTH-1:0] mem [MAXFIL][MAXIMG];

    logic          degen, accept, emit;
    logic [XW-1:0] rb, cb, fill_rows, span;
    logic [WB-1:0] win;

    // (a + b) mod f for a < f and b <= MAXSTRIDE, without a divider
    function automatic logic [XW-1:0] mod_add(input logic [XW-1:0] a,
                                              input logic [XW-1:0] b,
                                              input logic [XW-1:0] f);
        logic [XW-1:0] s;
        s = a + b;
        for (int k = 0; k <= MAXSTRIDE; k++) begin
            if (s >= f) s = s - f;
        end
        return s;
    endfunction

    assign degen  = (fil_size == '0) ||
                    (XW'(fil_size) > XW'(img_size) + (XW'(pad_size) << 1));
    assign accept = (state == S_WAIT) && buf_req;
    assign span   = n_r + p_r + p_r;

    // Readiness of the current window, input throttling and FSM outputs
    always_comb begin
        rb        = (row_base + f_r - 1 >= p_r + n_r) ? n_r - 1 : row_base + f_r - 1 - p_r;
        cb        = (col_base + f_r - 1 >= p_r + n_r) ? n_r - 1 : col_base + f_r - 1 - p_r;
        fill_rows = (f_r - p_r < n_r) ? f_r - p_r : n_r;
        emit      = ((state == S_RUN) || (state == S_DRAIN)) && !win_done &&
                    ((cm_row > rb) || ((cm_row == rb) && (cm_col > cb)));
        // A new row may only be requested once it cannot overwrite a row the
        // pending window still needs (row r lands on the line of row r-F).
        buf_ready = ((state == S_FILL) || (state == S_RUN)) && (in_row < n_r) &&
                    (win_done || (in_row + p_r < row_base + f_r));
        buf_ack   = (state == S_DONE);
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_WAIT:  if (buf_req) state_n = degen ? S_DONE : S_FILL;
            S_FILL:  if (cm_row >= fill_rows) state_n = S_RUN;
            S_RUN:   if (cm_row == n_r) state_n = S_DRAIN;
            S_DRAIN: if (win_done) state_n = S_DONE;
            S_DONE:  state_n = S_WAIT;
            default: state_n = S_WAIT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_n;
    end

    // Config latch, issue/commit counters and window scan position
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r <= '0; f_r <= '0; p_r <= '0; s_r <= '0;
            in_row <= '0; in_col <= '0; in_sel <= '0;
            cm_row <= '0; cm_col <= '0;
            row_base <= '0; col_base <= '0; top_sel <= '0;
            win_done <= 1'b0;
            wr_vld_p0 <= 1'b0;
        end else begin
            wr_vld_p0 <= buf_ready;
            if (accept) begin
                n_r <= XW'(img_size);
                f_r <= XW'(fil_size);
                p_r <= XW'(pad_size);
                s_r <= (stride_size == '0) ? XW'(1) : XW'(stride_size);
                in_row <= '0; in_col <= '0; in_sel <= '0;
                cm_row <= '0; cm_col <= '0;
                row_base <= '0; col_base <= '0;
                // line of padded row 0, i.e. image row -P taken modulo F
                top_sel <= (pad_size == '0) ? '0 : XW'(fil_size) - XW'(pad_size);
                win_done <= 1'b0;
            end else begin
                if (buf_ready) begin
                    if (in_col == n_r - 1) begin
                        in_col <= '0;
                        in_row <= in_row + 1;
                        in_sel <= (in_sel == f_r - 1) ? '0 : in_sel + 1;
                    end else begin
                        in_col <= in_col + 1;
                    end
                end
                if (wr_vld_p0) begin
                    if (cm_col == n_r - 1) begin
                        cm_col <= '0;
                        cm_row <= cm_row + 1;
                    end else begin
                        cm_col <= cm_col + 1;
                    end
                end
                if (emit) begin
                    if (col_base + s_r + f_r > span) begin
                        col_base <= '0;
                        if (row_base + s_r + f_r > span) begin
                            win_done <= 1'b1;
                        end else begin
                            row_base <= row_base + s_r;
                            top_sel  <= mod_add(top_sel, s_r, f_r);
                        end
                    end else begin
                        col_base <= col_base + s_r;
                    end
                end
            end
        end
    end

    // ---- stage p0: write address follows the ready cycle; pixel lands one cycle later
    always_ff @(posedge clk) begin
        wr_sel_p0 <= in_sel[SW-1:0];
        wr_col_p0 <= in_col[AW-1:0];
        if (wr_vld_p0) mem[wr_sel_p0][wr_col_p0] <= buf_input;
    end

    // Window gather: reorder lines so di=0 is the oldest row, zero pad and unused slots
    always_comb begin
        logic [XW-1:0] pr, pc, sel;
        logic [AW-1:0] col;
        int            idx;
        win = '0;
        idx = 0;
        pr  = '0;
        pc  = '0;
        sel = '0;
        col = '0;
        for (int di = 0; di < MAXFIL; di++) begin
            for (int dj = 0; dj < MAXFIL; dj++) begin
                pr  = row_base + XW'(di);
                pc  = col_base + XW'(dj);
                sel = top_sel + XW'(di);
                if (sel >= f_r) sel = sel - f_r;
                col = AW'(pc - p_r);
                if ((XW'(di) < f_r) && (XW'(dj) < f_r)) begin
                    if ((pr >= p_r) && (pr < p_r + n_r) && (pc >= p_r) && (pc < p_r + n_r))
                        win[idx*DWIDTH +: DWIDTH] = mem[sel[SW-1:0]][col];
                    idx = idx + 1;
                end
            end
        end
    end

    // ---- stage p1: registered window output, held while no window is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid  <= 1'b0;
            buf_output <= '0;
        end else begin
            buf_valid <= emit;
            if (emit) buf_output <= win;
        end
    end

endmodule

// File: tb/tb_renkon_linebuf_stride.sv
// Randomized/ramp bench for renkon_linebuf_stride against an im2col reference model.
module tb_renkon_linebuf_stride;
    localparam int MAXFIL    = 5;
    localparam int MAXIMG    = 32;
    localparam int MAXSTRIDE = 4;
    localparam int DWIDTH    = 16;
    localparam int LWIDTH    = 10;
    localparam int WB        = MAXFIL * MAXFIL * DWIDTH;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     buf_req;
    logic [LWIDTH-1:0]        img_size, fil_size, pad_size, stride_size;
    logic signed [DWIDTH-1:0] buf_input;
    logic                     buf_ack, buf_ready, buf_valid;
    logic [WB-1:0]            buf_output;

    renkon_linebuf_stride #(
        .MAXFIL(MAXFIL), .MAXIMG(MAXIMG), .MAXSTRIDE(MAXSTRIDE),
        .DWIDTH(DWIDTH), .LWIDTH(LWIDTH)
    ) dut (
        .clk(clk), .rst(rst), .buf_req(buf_req),
        .img_size(img_size), .fil_size(fil_size), .pad_size(pad_size),
        .stride_size(stride_size), .buf_input(buf_input),
        .buf_ack(buf_ack), .buf_ready(buf_ready), .buf_valid(buf_valid),
        .buf_output(buf_output)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            img [MAXIMG*MAXIMG];
    logic [WB-1:0] expq [$];

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // im2col over the zero-padded image; slot F*di+dj, everything else 0
    task automatic build_model(input int n, input int f, input int p, input int s);
        int            seff, r, c, v;
        logic [WB-1:0] w;
        expq.delete();
        seff = (s == 0) ? 1 : s;
        if (f == 0 || f > n + 2*p) return;
        for (int pr = 0; pr + f <= n + 2*p; pr += seff) begin
            for (int pc = 0; pc + f <= n + 2*p; pc += seff) begin
                w = '0;
                for (int di = 0; di < f; di++) begin
                    for (int dj = 0; dj < f; dj++) begin
                        r = pr + di - p;
                        c = pc + dj - p;
                        v = (r >= 0 && r < n && c >= 0 && c < n) ? img[r*n + c] : 0;
                        w[(f*di + dj)*DWIDTH +: DWIDTH] = DWIDTH'(v);
                    end
                end
                expq.push_back(w);
            end
        end
    endtask

    task automatic run_job(input string name, input int n, input int f, input int p,
                           input int s, input bit rnd, input int abort_after,
                           input int glitch_cyc);
        int         rdy, nwin, acks, last_v, ack_cyc, addr, abort_cyc, post_abort;
        bit         pend, finished, deg;
        logic [15:0] rv;
        for (int k = 0; k < n*n; k++) begin
            if (rnd) begin
                rv = 16'($urandom);
                img[k] = int'($signed(rv));
            end else begin
                img[k] = k + 1;
            end
        end
        build_model(n, f, p, s);
        deg = (f == 0) || (f > n + 2*p);
        rdy = 0; nwin = 0; acks = 0; last_v = -10; ack_cyc = -1; addr = 0;
        abort_cyc = -1; post_abort = 0; pend = 1'b0; finished = 1'b0;

        @(posedge clk); #1;
        img_size    = LWIDTH'(n);
        fil_size    = LWIDTH'(f);
        pad_size    = LWIDTH'(p);
        stride_size = LWIDTH'(s);
        buf_req     = 1'b1;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (abort_cyc >= 0 && cyc >= abort_cyc + 2) begin
                if (cyc == abort_cyc + 2) begin
                    chk({name, " rst_ready"}, WB'(buf_ready), '0);
                    chk({name, " rst_valid"}, WB'(buf_valid), '0);
                    chk({name, " rst_ack"},   WB'(buf_ack),   '0);
                    chk({name, " rst_output"}, buf_output,    '0);
                end
                if (buf_valid) post_abort++;
                if (buf_ack) acks++;
                if (cyc >= abort_cyc + 30) begin
                    finished = 1'b1;
                    break;
                end
            end else begin
                if (buf_ready) begin
                    rdy++;
                    pend = 1'b1;
                end
                if (buf_valid) begin
                    if (nwin < expq.size())
                        chk($sformatf("%s win%0d", name, nwin), buf_output, expq[nwin]);
                    else
                        chk($sformatf("%s extra_win", name), WB'(nwin + 1), WB'(expq.size()));
                    nwin++;
                    last_v = cyc;
                end
                if (buf_ack) begin
                    acks++;
                    if (acks == 1) ack_cyc = cyc;
                end
                if (acks > 0 && cyc >= ack_cyc + 6) begin
                    finished = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            if (cyc == 0 || cyc == glitch_cyc + 1) buf_req = 1'b0;
            if (cyc == glitch_cyc) begin
                buf_req  = 1'b1;
                img_size = LWIDTH'(8);
                fil_size = LWIDTH'(3);
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) rst = 1'b0;
            if (abort_after > 0 && abort_cyc < 0 && nwin >= abort_after) begin
                rst = 1'b1;
                abort_cyc = cyc;
            end
            if (pend) begin
                if (addr < n*n) buf_input = DWIDTH'(img[addr]);
                addr++;
                pend = 1'b0;
            end
        end
        buf_req = 1'b0;

        if (!finished) chk({name, " timeout"}, '0, WB'(1));
        if (abort_after > 0) begin
            chk({name, " abort_acks"},  WB'(acks), '0);
            chk({name, " abort_valid"}, WB'(post_abort), '0);
        end else begin
            chk({name, " ready_count"}, WB'(rdy), deg ? '0 : WB'(n*n));
            chk({name, " win_count"},   WB'(nwin), WB'(expq.size()));
            chk({name, " ack_count"},   WB'(acks), WB'(1));
            if (deg) chk({name, " ack_latency"}, WB'(ack_cyc), WB'(1));
            else     chk({name, " ack_latency"}, WB'(ack_cyc), WB'(last_v + 1));
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; buf_req = 1'b0; buf_input = '0;
        img_size = '0; fil_size = '0; pad_size = '0; stride_size = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",  WB'(buf_ready), '0);
        chk("reset_valid",  WB'(buf_valid), '0);
        chk("reset_ack",    WB'(buf_ack),   '0);
        chk("reset_output", buf_output,     '0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_job("ramp_s1",    8, 3, 1, 1, 1'b0, 0, -1);
        run_job("ramp_s2",    8, 3, 1, 2, 1'b0, 0, -1);
        run_job("rand_f5",   32, 5, 0, 1, 1'b1, 0, -1);
        run_job("rand_p2s3", 32, 5, 2, 3, 1'b1, 0, -1);
        run_job("f1_s0",      4, 1, 0, 0, 1'b0, 0, 5);
        run_job("f0_degen",   8, 0, 0, 1, 1'b0, 0, -1);
        run_job("big_f",      2, 5, 1, 1, 1'b0, 0, -1);
        run_job("abort",      8, 3, 1, 1, 1'b0, 10, -1);
        run_job("after_rst",  8, 3, 1, 1, 1'b1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
